mem_access_sequencer: RTL

//  MEM-stage responder for the control word's memory fields (mem_read, mem_write, indirect_enable, mem_byte_enable).

---
 rtl/mem_access_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// MEM-stage sequencer: turns LOAD/STORE/LDI/STI control words into one or two
// handshaked data-cache transactions and stalls the pipeline until the final response.
module mem_access_sequencer #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  indirect_enable_i,
    input  logic [1:0]            mem_byte_enable_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic                  dmem_resp_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  dmem_read_o,
    output logic                  dmem_write_o,
    output logic [1:0]            dmem_byte_enable_o,
    output logic [ADDR_WIDTH-1:0] dmem_address_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic                  mem_stall_o,
    output logic                  mem_done_o,
    output logic [DATA_WIDTH-1:0] mem_rdata_o,
    output logic [CNT_WIDTH-1:0]  stall_count_o
);

    typedef enum logic [1:0] {StIdle, StFirst, StSecond, StDone} state_e;
    typedef enum logic [2:0] {KindNone, KindLoad, KindStore, KindLdi, KindSti} kind_e;

    state_e                state_q, state_d;
    kind_e                 kind_q, kind_d, kind_dec;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            be_q, be_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    always_comb begin
        kind_dec = KindNone;
        if (req_valid_i) begin
            if (indirect_enable_i) begin
                kind_dec = mem_read_i ? KindLdi : KindSti;
            end else if (mem_read_i) begin
                kind_dec = KindLoad;
            end else if (mem_write_i) begin
                kind_dec = KindStore;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        kind_d             = kind_q;
        addr_d             = addr_q;
        ptr_d              = ptr_q;
        wdata_d            = wdata_q;
        rdata_d            = rdata_q;
        be_d               = be_q;
        dmem_read_o        = 1'b0;
        dmem_write_o       = 1'b0;
        dmem_byte_enable_o = 2'b00;
        dmem_address_o     = '0;
        dmem_wdata_o       = '0;
        mem_stall_o        = 1'b0;
        mem_done_o         = 1'b0;

        case (state_q)
            StIdle: begin
                if (kind_dec != KindNone) begin
                    mem_stall_o = 1'b1;
                    state_d     = StFirst;
                    kind_d      = kind_dec;
                    addr_d      = req_addr_i;
                    wdata_d     = req_wdata_i;
                    be_d        = mem_byte_enable_i;
                end
            end
            StFirst: begin
                mem_stall_o    = 1'b1;
                dmem_address_o = addr_q;
                if (kind_q == KindStore) begin
                    dmem_write_o       = 1'b1;
                    dmem_byte_enable_o = be_q;
                    dmem_wdata_o       = wdata_q;
                end else begin
                    dmem_read_o = 1'b1;
                end
                if (dmem_resp_i) begin
                    case (kind_q)
                        KindLoad: begin
                            rdata_d = dmem_rdata_i;
                            state_d = StDone;
                        end
                        KindStore: state_d = StDone;
                        KindLdi, KindSti: begin
                            // Pointers are word aligned; the low bit of the fetched word is dropped.
                            ptr_d   = {dmem_rdata_i[ADDR_WIDTH-1:1], 1'b0};
                            state_d = StSecond;
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StSecond: begin
                mem_stall_o    = 1'b1;
                dmem_address_o = ptr_q;
                if (kind_q == KindSti) begin
                    dmem_write_o       = 1'b1;
                    dmem_byte_enable_o = 2'b11;
                    dmem_wdata_o       = wdata_q;
                end else begin
                    dmem_read_o = 1'b1;
                end
                if (dmem_resp_i) begin
                    if (kind_q == KindLdi) begin
                        rdata_d = dmem_rdata_i;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                mem_done_o = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mem_stall_o && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            kind_q  <= KindNone;
            addr_q  <= '0;
            ptr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_rdata_o   = rdata_q;
    assign stall_count_o = cnt_q;

endmodule
